// File: rtl/n1_core.sv
// -----------------------------------------------------------------------------
// n1_core -- accumulator-style 8-bit execution core.
//
// Multi-cycle FSM that fetches one- and two-byte instructions from program RAM.
// It reads and writes data RAM through a single-port request interface, with
// at most one access in flight at any time.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   run        start request, sampled only in IDLE and HALT
//   mem_req    one-cycle access strobe
//   mem_wr     1 = write, 0 = read (meaningful only with mem_req)
//   mem_sel    0 = program RAM, 1 = data RAM
//   mem_addr   access address
//   mem_wdata  write data (always the accumulator)
//   mem_rdata  read data, valid the cycle after a read strobe
//   acc        accumulator
//   flag_z     acc == 0 after the last accumulator update
//   flag_c     carry from ADD / no-borrow from SUB
//   pc         program counter
//   halted     high while in HALT
// -----------------------------------------------------------------------------
module n1_core #(
  parameter  int RAM_BYTES = 64,
  localparam int AW        = $clog2(RAM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          mem_req,
  output logic          mem_wr,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    acc,
  output logic          flag_z,
  output logic          flag_c,
  output logic [AW-1:0] pc,
  output logic          halted
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_F_OP,
    ST_D_OP,
    ST_F_ARG,
    ST_D_ARG,
    ST_RD,
    ST_EX,
    ST_WR,
    ST_HALT
  } state_t;

  // Opcodes C-E have no name: they fall into the NOP path through the
  // default branches below.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDA = 4'h2,
    OP_STA = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_JNZ = 4'hB,
    OP_HLT = 4'hF
  } opcode_t;

  state_t        state;
  opcode_t       opcode;
  logic [AW-1:0] operand;

  // Increment modulo RAM_BYTES; also correct when RAM_BYTES is not a power
  // of two, where the natural binary wrap would overshoot the memory.
  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] p);
    return (p == AW'(RAM_BYTES - 1)) ? '0 : p + AW'(1);
  endfunction

  // Two-byte opcodes need an operand fetch; everything else is one byte.
  function automatic logic has_arg(input logic [3:0] op);
    case (op)
      OP_LDI, OP_LDA, OP_STA, OP_ADD, OP_SUB,
      OP_AND, OP_OR,  OP_XOR, OP_JMP, OP_JZ, OP_JNZ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath for the EX state: result and carry computed from the data byte
  // returned by the RD access.
  // ---------------------------------------------------------------------------
  logic [8:0] add_sum;
  logic [8:0] sub_sum;
  logic [7:0] alu_res;
  logic       alu_c;

  assign add_sum = {1'b0, acc} + {1'b0, mem_rdata};
  // Two's-complement subtract; bit 8 set means no borrow occurred.
  assign sub_sum = {1'b0, acc} + {1'b0, ~mem_rdata} + 9'd1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = mem_rdata;
    alu_c   = flag_c;
    case (opcode)
      OP_ADD: {alu_c, alu_res} = add_sum;
      OP_SUB: {alu_c, alu_res} = sub_sum;
      OP_AND: alu_res = acc & mem_rdata;
      OP_OR:  alu_res = acc | mem_rdata;
      OP_XOR: alu_res = acc ^ mem_rdata;
      default: ;  // LDA: plain load of the data byte
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory request decode: purely a function of state and registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    mem_sel  = 1'b0;
    mem_addr = '0;
    case (state)
      ST_F_OP, ST_F_ARG: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      ST_RD: begin
        mem_req  = 1'b1;
        mem_sel  = 1'b1;
        mem_addr = operand;
      end
      ST_WR: begin
        mem_req  = 1'b1;
        mem_wr   = 1'b1;
        mem_sel  = 1'b1;
        mem_addr = operand;
      end
      default: ;
    endcase
  end

  assign mem_wdata = acc;

  // ---------------------------------------------------------------------------
  // Control FSM and architectural state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      opcode  <= OP_NOP;
      operand <= '0;
      pc      <= '0;
      acc     <= '0;
      flag_z  <= 1'b1;
      flag_c  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            pc    <= '0;
            state <= ST_F_OP;
          end
        end

        ST_F_OP: state <= ST_D_OP;

        ST_D_OP: begin
          opcode <= opcode_t'(mem_rdata[7:4]);
          pc     <= pc_inc(pc);
          if (mem_rdata[7:4] == OP_HLT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (has_arg(mem_rdata[7:4])) begin
            state <= ST_F_ARG;
          end else begin
            state <= ST_F_OP;
          end
        end

        ST_F_ARG: state <= ST_D_ARG;

        ST_D_ARG: begin
          operand <= mem_rdata[AW-1:0];
          pc      <= pc_inc(pc);
          state   <= ST_F_OP;
          case (opcode)
            OP_LDI: begin
              acc    <= mem_rdata;
              flag_z <= (mem_rdata == 8'h00);
            end
            // A taken jump overrides the increment above (last NBA wins).
            OP_JMP: pc <= mem_rdata[AW-1:0];
            OP_JZ:  if (flag_z)  pc <= mem_rdata[AW-1:0];
            OP_JNZ: if (!flag_z) pc <= mem_rdata[AW-1:0];
            OP_STA: state <= ST_WR;
            default: state <= ST_RD;  // LDA and ALU ops
          endcase
        end

        ST_RD: state <= ST_EX;

        ST_EX: begin
          acc    <= alu_res;
          flag_z <= (alu_res == 8'h00);
          flag_c <= alu_c;
          state  <= ST_F_OP;
        end

        ST_WR: state <= ST_F_OP;

        ST_HALT: begin
          if (!run) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
